// File: rtl/tone_organ_if.sv
// rtl/tone_organ_if.sv - note-select and tone-output bundle for tone_organ
interface tone_organ_if;
    logic [2:0] sel;
    logic       outclk;

    modport master (output sel, input outclk);
    modport slave  (input sel, output outclk);
endinterface

// File: rtl/tone_organ.sv
// rtl/tone_organ.sv - eight-note square-wave tone generator
// Divides inclk by 2*N(sel) with half-periods fixed at elaboration.
module tone_organ #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned F_DO   = 523,
    parameter int unsigned F_RE   = 587,
    parameter int unsigned F_MI   = 659,
    parameter int unsigned F_FA   = 698,
    parameter int unsigned F_SO   = 783,
    parameter int unsigned F_LA   = 880,
    parameter int unsigned F_SI   = 987,
    parameter int unsigned F_DO2  = 1046,
    parameter int unsigned CNT_W  = 32
) (
    input  logic         inclk,
    input  logic         reset,
    tone_organ_if.slave  bus
);

    localparam logic [CNT_W-1:0] N_DO  = CNT_W'(CLK_HZ / (2 * F_DO));
    localparam logic [CNT_W-1:0] N_RE  = CNT_W'(CLK_HZ / (2 * F_RE));
    localparam logic [CNT_W-1:0] N_MI  = CNT_W'(CLK_HZ / (2 * F_MI));
    localparam logic [CNT_W-1:0] N_FA  = CNT_W'(CLK_HZ / (2 * F_FA));
    localparam logic [CNT_W-1:0] N_SO  = CNT_W'(CLK_HZ / (2 * F_SO));
    localparam logic [CNT_W-1:0] N_LA  = CNT_W'(CLK_HZ / (2 * F_LA));
    localparam logic [CNT_W-1:0] N_SI  = CNT_W'(CLK_HZ / (2 * F_SI));
    localparam logic [CNT_W-1:0] N_DO2 = CNT_W'(CLK_HZ / (2 * F_DO2));

    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] n_sel;
    logic [CNT_W-1:0] n_last;

    always_comb begin
        n_sel = N_DO;
        case (sel_q)
            3'd0:    n_sel = N_DO;
            3'd1:    n_sel = N_RE;
            3'd2:    n_sel = N_MI;
            3'd3:    n_sel = N_FA;
            3'd4:    n_sel = N_SO;
            3'd5:    n_sel = N_LA;
            3'd6:    n_sel = N_SI;
            default: n_sel = N_DO2;
        endcase
    end

    assign n_last = n_sel - CNT_W'(1);

    // A note change restarts the half-period without touching the output level;
    // >= keeps the counter from running past the wrap after a switch to a shorter note.
    always_comb begin
        sel_d = bus.sel;
        cnt_d = cnt_q + CNT_W'(1);
        out_d = out_q;
        if (bus.sel != sel_q) begin
            cnt_d = '0;
        end else if (cnt_q >= n_last) begin
            cnt_d = '0;
            out_d = ~out_q;
        end
    end

    always_ff @(posedge inclk) begin
        if (reset) begin
            sel_q <= bus.sel;
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign bus.outclk = out_q;

endmodule

// File: tb/tb_tone_organ.sv
// tb/tb_tone_organ.sv - self-checking bench for tone_organ
module tb_tone_organ;

    localparam longint SMALL_HZ = 500_000;
    localparam longint DEF_HZ   = 50_000_000;

    logic inclk = 1'b0;
    logic reset = 1'b1;
    always #10 inclk = ~inclk;

    tone_organ_if bus ();
    tone_organ_if bus_def ();

    tone_organ #(.CLK_HZ(SMALL_HZ)) dut (
        .inclk (inclk),
        .reset (reset),
        .bus   (bus)
    );

    tone_organ dut_def (
        .inclk (inclk),
        .reset (reset),
        .bus   (bus_def)
    );

    int     n_cmp  = 0;
    int     n_fail = 0;
    longint cyc    = 0;

    // Reference model: output level plus the absolute edge at which it next flips.
    logic       m_level    = 1'b0;
    longint     m_deadline = 0;
    logic [2:0] m_prev_sel = 3'd0;

    function automatic longint freq_of(input int s);
        case (s)
            0: return 523;
            1: return 587;
            2: return 659;
            3: return 698;
            4: return 783;
            5: return 880;
            6: return 987;
            default: return 1046;
        endcase
    endfunction

    function automatic longint exp_n(input int s, input longint hz);
        return hz / (2 * freq_of(s));
    endfunction

    task automatic tick();
        logic       r;
        logic [2:0] s;
        r = reset;
        s = bus.sel;
        @(posedge inclk);
        cyc++;
        if (r) begin
            m_level    = 1'b0;
            m_prev_sel = s;
            m_deadline = cyc + exp_n(int'(s), SMALL_HZ);
        end else if (s != m_prev_sel) begin
            m_prev_sel = s;
            m_deadline = cyc + exp_n(int'(s), SMALL_HZ);
        end else if (cyc == m_deadline) begin
            m_level    = ~m_level;
            m_deadline = cyc + exp_n(int'(s), SMALL_HZ);
        end
        #1;
    endtask

    task automatic wait_level(input logic lvl, input int budget, output longint t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.outclk === lvl) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit seen_high;
        reset = 1'b1;
        bus.sel = 3'($urandom_range(0, 7));
        tick();
        n_cmp++;
        if (bus.outclk !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got %b expected 0", bus.outclk);
        end
        n_cmp++;
        if (bus_def.outclk !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_def: got %b expected 0", bus_def.outclk);
        end
        seen_high = 1'b0;
        repeat (600) begin
            tick();
            if (bus.outclk !== 1'b0) seen_high = 1'b1;
        end
        n_cmp++;
        if (seen_high !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_out: outclk rose during held reset, expected stay 0");
        end
        n_cmp++;
        if (dut.cnt_q !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hold_cnt: got %0d expected 0", dut.cnt_q);
        end
    endtask

    task automatic test_default_first_rise();
        longint r;
        longint t;
        bus_def.sel = 3'd7;
        reset = 1'b1;
        tick();
        r = cyc;
        reset = 1'b0;
        t = -1;
        for (int i = 0; i < 30000; i++) begin
            tick();
            if (bus_def.outclk === 1'b1) begin
                t = cyc;
                break;
            end
        end
        n_cmp++;
        if (t - r !== exp_n(7, DEF_HZ)) begin
            n_fail++;
            $display("FAIL default_first_rise: got %0d expected %0d", t - r, exp_n(7, DEF_HZ));
        end
    endtask

    task automatic test_half_periods();
        longint r, t1, t2, t3, n;
        for (int s = 0; s < 8; s++) begin
            n = exp_n(s, SMALL_HZ);
            bus.sel = 3'(s);
            reset = 1'b1;
            tick();
            r = cyc;
            reset = 1'b0;
            wait_level(1'b1, 4 * int'(n), t1);
            wait_level(1'b0, 4 * int'(n), t2);
            wait_level(1'b1, 4 * int'(n), t3);
            n_cmp++;
            if (t1 - r !== n) begin
                n_fail++;
                $display("FAIL first_rise sel=%0d: got %0d expected %0d", s, t1 - r, n);
            end
            n_cmp++;
            if (t2 - t1 !== n) begin
                n_fail++;
                $display("FAIL high_phase sel=%0d: got %0d expected %0d", s, t2 - t1, n);
            end
            n_cmp++;
            if (t3 - t2 !== n) begin
                n_fail++;
                $display("FAIL low_phase sel=%0d: got %0d expected %0d", s, t3 - t2, n);
            end
        end
    endtask

    task automatic test_reset_mid_high();
        longint t;
        bus.sel = 3'd3;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_level(1'b1, 2000, t);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (bus.outclk !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_high: got %b expected 0", bus.outclk);
        end
        repeat (5) tick();
        n_cmp++;
        if (bus.outclk !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_high_hold: got %b expected 0", bus.outclk);
        end
        reset = 1'b0;
    endtask

    task automatic test_sel_switch();
        longint t, e0;
        bus.sel = 3'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_level(1'b1, 2000, t);
        repeat (100) tick();
        bus.sel = 3'd5;
        tick();
        e0 = cyc;
        n_cmp++;
        if (bus.outclk !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_level_held: got %b expected 1", bus.outclk);
        end
        wait_level(1'b0, 2000, t);
        n_cmp++;
        if (t - e0 !== exp_n(5, SMALL_HZ)) begin
            n_fail++;
            $display("FAIL switch_toggle_delay: got %0d expected %0d", t - e0, exp_n(5, SMALL_HZ));
        end
    endtask

    task automatic test_glitch();
        longint t, e1;
        bus.sel = 3'd7;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (50) tick();
        bus.sel = 3'd0;
        tick();
        bus.sel = 3'd7;
        tick();
        e1 = cyc;
        n_cmp++;
        if (bus.outclk !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_level_held: got %b expected 0", bus.outclk);
        end
        wait_level(1'b1, 2000, t);
        n_cmp++;
        if (t - e1 !== exp_n(7, SMALL_HZ)) begin
            n_fail++;
            $display("FAIL glitch_toggle_delay: got %0d expected %0d", t - e1, exp_n(7, SMALL_HZ));
        end
        n_cmp++;
        if (dut.cnt_q > 32'(exp_n(7, SMALL_HZ))) begin
            n_fail++;
            $display("FAIL glitch_cnt_range: got %0d limit %0d", dut.cnt_q, exp_n(7, SMALL_HZ));
        end
    endtask

    task automatic test_random();
        int         rst_left;
        logic [2:0] back;
        rst_left = 0;
        reset = 1'b1;
        bus.sel = 3'($urandom_range(0, 7));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (rst_left > 0) begin
                rst_left--;
                reset = (rst_left > 0);
            end else if ($urandom_range(0, 2999) == 0) begin
                rst_left = $urandom_range(2, 4);
                reset = 1'b1;
            end
            if ($urandom_range(0, 1199) == 0) begin
                bus.sel = 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 2999) == 0) begin
                back = bus.sel;
                bus.sel = 3'($urandom_range(0, 7));
                tick();
                bus.sel = back;
            end
            tick();
            n_cmp++;
            if (bus.outclk !== m_level) begin
                n_fail++;
                $display("FAIL random_out cyc=%0d: got %b expected %b", cyc, bus.outclk, m_level);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.sel     = 3'd0;
        bus_def.sel = 3'd7;
        reset       = 1'b1;
        test_reset();
        test_default_first_rise();
        test_half_periods();
        test_reset_mid_high();
        test_sel_switch();
        test_glitch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
